updown_cntr_monitor: RTL

//   Observer for the 3-bit up/down counter output stream. Samples the count value,

---
 rtl/updown_cntr_monitor.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/updown_cntr_monitor.sv
// -----------------------------------------------------------------------------
// updown_cntr_monitor
//
// Purpose:
//   On-chip observer for an up/down counter output stream. Each valid sample
//   is compared with the previous one and classified as HOLD, UP, DOWN or
//   JUMP (all arithmetic modulo 2^WIDTH). The block also:
//     - tracks the direction of travel,
//     - counts wrap-arounds,
//     - pulses on direction reversals,
//     - counts and flags jumps that were not announced as loads.
//
// Optional feature (macro UDMON_HIST_EN):
//   When defined, adds output hist[7:0] holding the last four event codes,
//   with the newest code in bits [1:0].
//
// Ports:
//   clk        in   1      clock; all state updates on the rising edge
//   rst_       in   1      synchronous reset, active-high
//   sample_vld in   1      cnt_in carries a valid sample this cycle
//   cnt_in     in   WIDTH  observed counter value
//   ld_hint    in   1      a load accompanies this sample, so a jump is legal
//   clr_err    in   1      clears err_cnt and err_flag
//   evt_vld    out  1      one-cycle pulse: evt_code is valid
//   evt_code   out  2      event class: 00 HOLD, 01 UP, 10 DOWN, 11 JUMP
//   dir        out  2      direction state: 00 NOREF, 01 HOLD, 10 UP, 11 DN
//   rev_pulse  out  1      one-cycle pulse on a direction reversal
//   wrap_cnt   out  WRAPW  wrap-arounds seen (free-running)
//   err_cnt    out  ERRW   unannounced jumps (saturating)
//   err_flag   out  1      sticky error indicator
//   hist       out  8      last four event codes (UDMON_HIST_EN only)
// -----------------------------------------------------------------------------
module updown_cntr_monitor #(
  parameter int WIDTH = 3,
  parameter int WRAPW = 4,
  parameter int ERRW  = 4
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             sample_vld,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             ld_hint,
  input  logic             clr_err,
  output logic             evt_vld,
  output logic [1:0]       evt_code,
  output logic [1:0]       dir,
  output logic             rev_pulse,
  output logic [WRAPW-1:0] wrap_cnt,
  output logic [ERRW-1:0]  err_cnt,
  output logic             err_flag
`ifdef UDMON_HIST_EN
  ,
  output logic [7:0]       hist
`endif
);

  localparam logic [1:0] EVT_HOLD = 2'b00;
  localparam logic [1:0] EVT_UP   = 2'b01;
  localparam logic [1:0] EVT_DOWN = 2'b10;
  localparam logic [1:0] EVT_JUMP = 2'b11;

  localparam logic [1:0] ST_NOREF = 2'b00;
  localparam logic [1:0] ST_HOLD  = 2'b01;
  localparam logic [1:0] ST_UP    = 2'b10;
  localparam logic [1:0] ST_DN    = 2'b11;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [ERRW-1:0]  ERR_MAX = '1;

  // Error counter increments and sticks at its maximum.
  function automatic logic [ERRW-1:0] err_sat_inc(input logic [ERRW-1:0] v);
    return (v == ERR_MAX) ? v : v + ERRW'(1);
  endfunction

  logic [WIDTH-1:0] prev_p1;
  logic [1:0]       cls_p0;
  logic             ref_ok_p0;
  logic             err_p0;
  logic             wrap_p0;
  logic             rev_p0;

  // Stage p0: classify the incoming sample against the stored previous value.
  always_comb begin
    cls_p0 = EVT_JUMP;
    if (cnt_in == prev_p1)
      cls_p0 = EVT_HOLD;
    else if (cnt_in == prev_p1 + WIDTH'(1))
      cls_p0 = EVT_UP;
    else if (cnt_in == prev_p1 - WIDTH'(1))
      cls_p0 = EVT_DOWN;

    ref_ok_p0 = sample_vld && (dir != ST_NOREF);
    err_p0    = ref_ok_p0 && (cls_p0 == EVT_JUMP) && !ld_hint;
    // A wrap is a single step across the max/zero boundary; jumps never wrap.
    wrap_p0   = ref_ok_p0 &&
                (((cls_p0 == EVT_UP)   && (prev_p1 == CNT_MAX)) ||
                 ((cls_p0 == EVT_DOWN) && (prev_p1 == '0)));
    // dir remembers the last real move across HOLD events, so a pause between
    // opposite moves still reports the reversal.
    rev_p0    = ref_ok_p0 &&
                (((cls_p0 == EVT_UP)   && (dir == ST_DN)) ||
                 ((cls_p0 == EVT_DOWN) && (dir == ST_UP)));
  end

  // Stage p1: registered outputs and tracking state.
  always_ff @(posedge clk) begin
    if (rst_) begin
      prev_p1   <= '0;
      evt_vld   <= 1'b0;
      evt_code  <= EVT_HOLD;
      dir       <= ST_NOREF;
      rev_pulse <= 1'b0;
      wrap_cnt  <= '0;
      err_cnt   <= '0;
      err_flag  <= 1'b0;
`ifdef UDMON_HIST_EN
      hist      <= 8'h00;
`endif
    end else begin
      evt_vld   <= 1'b0;
      rev_pulse <= 1'b0;

      if (sample_vld) begin
        prev_p1 <= cnt_in;
        if (dir == ST_NOREF) begin
          // First sample only establishes the reference.
          dir <= ST_HOLD;
        end else begin
          evt_vld   <= 1'b1;
          evt_code  <= cls_p0;
          rev_pulse <= rev_p0;
          case (cls_p0)
            EVT_UP:   dir <= ST_UP;
            EVT_DOWN: dir <= ST_DN;
            EVT_JUMP: dir <= ST_HOLD;
            default:  dir <= dir;
          endcase
          if (wrap_p0)
            wrap_cnt <= wrap_cnt + WRAPW'(1);
`ifdef UDMON_HIST_EN
          hist <= {hist[5:0], cls_p0};
`endif
        end
      end

      // A same-cycle error overrides the clear and restarts the count at one.
      if (err_p0) begin
        err_cnt  <= clr_err ? ERRW'(1) : err_sat_inc(err_cnt);
        err_flag <= 1'b1;
      end else if (clr_err) begin
        err_cnt  <= '0;
        err_flag <= 1'b0;
      end
    end
  end

endmodule
